// File: rtl/mem_stage.sv
// Memory stage: buffers one instruction, runs a single bus access for loads/stores
// and presents the writeback/forwarding result. Optional MEM_TIMEOUT_EN adds an access timeout and bus_err.
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic [31:0] alu_in,
   input  logic [31:0] store_in,
   input  logic [31:0] inst_in,
   input  logic [29:0] ip_in,
   input  logic [2:0]  wb_lines_in,
   input  logic        mem_req_in,
   input  logic        mem_we_in,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic        wb_en,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data
`ifdef MEM_TIMEOUT_EN
   ,
   output logic        bus_err
`endif
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] aluBuf_q, storeBuf_q, loadData_q;
   logic [29:0] ipBuf_q;
   logic [4:0]  rdBuf_q;
   logic [2:0]  wbLines_q;
   logic        memReq_q, memWe_q;
   logic        instValid_q, instValid_d;
   logic        capture, loadLatch, isStore;
   logic        unusedInstBits;

`ifdef MEM_TIMEOUT_EN
   logic [7:0]  count_q, count_d;
   logic        timedOut_q, busErr_q, timeout;
`endif

   assign unusedInstBits = ^{inst_in[31:26], inst_in[20:0]};

   assign capture   = clk_en && (state_q != ACCESS);
   assign loadLatch = (state_q == ACCESS) && mem_ready && !memWe_q;
   assign isStore   = memReq_q && memWe_q;

   // A held buffer must not write back twice, so validity lasts only one
   // non-stalled cycle after capture.
   assign instValid_d = capture ? 1'b1 : ((state_q == ACCESS) ? instValid_q : 1'b0);

   // DONE leaves after one cycle; a memory instruction captured in DONE
   // starts its access immediately instead of being dropped.
   always_comb begin
      state_d = state_q;
`ifdef MEM_TIMEOUT_EN
      timeout = 1'b0;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (capture && mem_req_in) state_d = ACCESS;
            else                       state_d = IDLE;
         end
         ACCESS: begin
            if (mem_ready) begin
               state_d = DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (count_q == 8'd255) begin
               state_d = DONE;
               timeout = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         aluBuf_q    <= '0;
         storeBuf_q  <= '0;
         ipBuf_q     <= '0;
         rdBuf_q     <= '0;
         wbLines_q   <= '0;
         memReq_q    <= 1'b0;
         memWe_q     <= 1'b0;
         instValid_q <= 1'b0;
         loadData_q  <= '0;
      end else begin
         state_q     <= state_d;
         instValid_q <= instValid_d;
         if (capture) begin
            aluBuf_q   <= alu_in;
            storeBuf_q <= store_in;
            ipBuf_q    <= ip_in;
            rdBuf_q    <= inst_in[25:21];
            wbLines_q  <= wb_lines_in;
            memReq_q   <= mem_req_in;
            memWe_q    <= mem_we_in;
         end
         if (loadLatch) begin
            loadData_q <= mem_rdata;
         end
`ifdef MEM_TIMEOUT_EN
         else if (timeout) begin
            loadData_q <= '0;
         end
`endif
      end
   end

`ifdef MEM_TIMEOUT_EN
   // count_q holds the number of the current ACCESS cycle, starting at 1.
   always_comb begin
      count_d = count_q;
      if (capture && mem_req_in)
         count_d = 8'd1;
      else if ((state_q == ACCESS) && !mem_ready && (count_q != 8'd255))
         count_d = count_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         timedOut_q <= 1'b0;
         busErr_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         if (capture)      timedOut_q <= 1'b0;
         else if (timeout) timedOut_q <= 1'b1;
         if (timeout)      busErr_q   <= 1'b1;
      end
   end

   assign bus_err = busErr_q;
`endif

   assign mem_valid = (state_q == ACCESS);
   assign stall     = (state_q == ACCESS);
   assign mem_we    = (state_q == ACCESS) && memWe_q;
   assign mem_addr  = aluBuf_q;
   assign mem_wdata = storeBuf_q;
   assign wb_addr   = rdBuf_q;

   always_comb begin
      wb_en = wbLines_q[0] && (rdBuf_q != 5'd0) && (state_q != ACCESS) &&
              instValid_q && !isStore;
`ifdef MEM_TIMEOUT_EN
      wb_en = wb_en && !timedOut_q;
`endif
   end

   always_comb begin
      wb_data = '0;
      case (wbLines_q[2:1])
         2'd0:    wb_data = aluBuf_q;
         2'd1:    wb_data = loadData_q;
         2'd2:    wb_data = {ipBuf_q + 30'd1, 2'b00};
         default: wb_data = '0;
      endcase
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 clk_en  in  1  capture enable for the input buffer; upstream drives it low while stall is high.
REQ-004 alu_in  in  32  execute-stage result; used as memory byte address and as ALU writeback data.
REQ-005 store_in  in  32  store data.
REQ-006 inst_in  in  32  instruction word; rd = inst[25:21].
REQ-007 ip_in  in  30  word instruction pointer of the instruction.
REQ-008 wb_lines_in  in  3  writeback control: [0] reg write, [2:1] source (0 ALU, 1 MEM, 2 return address, 3 reserved).
REQ-009 mem_req_in, mem_we_in  in  1 each  memory access request; write when mem_we_in=1.
REQ-010 mem_valid, mem_we  out  1 each  bus request and its direction.
REQ-011 mem_addr, mem_wdata  out  32 each  bus address and write data.
REQ-012 mem_ready  in  1  bus accepts or completes the access in this cycle.
REQ-013 mem_rdata  in  32  load data, valid when mem_valid&&mem_ready&&!mem_we.
REQ-014 stall  out  1  access outstanding; upstream holds.
REQ-015 wb_en, wb_addr[4:0], wb_data[31:0]  out  writeback port; also the forwarding source (forward, rd_addr, write_in) for execute.
REQ-016 bus_err  out  1  sticky timeout flag; present only with MEM_TIMEOUT_EN.

Function
REQ-017 When clk_en=1 and stall=0, the block SHALL register all inputs into its buffer; otherwise the buffer SHALL hold its contents.
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-019 IDLE -> ACCESS SHALL occur on capture of an instruction with mem_req_in=1; any other capture SHALL leave the FSM in IDLE.
REQ-020 In ACCESS, mem_valid SHALL be 1, with mem_addr, mem_wdata and mem_we held constant until mem_ready=1.
REQ-021 ACCESS -> DONE SHALL occur on mem_valid&&mem_ready, latching mem_rdata for loads.
REQ-022 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-023 stall SHALL equal (state==ACCESS); minimum memory latency is 2 cycles, with the result in DONE.
REQ-024 For a non-memory instruction, wb_* SHALL be valid the cycle after capture, which is zero added stall.
REQ-025 wb_data SHALL be: ALU → alu buffer; MEM → latched load data; return address → {ip_buf+30'd1, 2'b00} mod 2^32; reserved → 0.
REQ-026 wb_en SHALL equal wb_lines[0] && rd!=0 && (state!=ACCESS), asserted for exactly one cycle per instruction.
REQ-027 A store SHALL NOT write back, regardless of wb_lines[0].
REQ-028 mem_ready while mem_valid=0 SHALL be ignored.
REQ-029 If clk_en=1 during stall, the input SHALL NOT be captured.

Reset
REQ-030 While rst_n=0, all of the following SHALL be 0: state=IDLE, buffers, mem_valid, mem_we, mem_addr, mem_wdata, stall, wb_en, wb_addr, wb_data and bus_err.
REQ-031 Reset asserted mid-access SHALL drop mem_valid immediately (asynchronously) and discard the access; no writeback SHALL occur.
REQ-032 Release of rst_n SHALL be sampled synchronously; the first capture can occur on the first rising edge after release.

Configuration
REQ-033 When MEM_TIMEOUT_EN is defined, an 8-bit counter SHALL count cycles in ACCESS; at count 255 without mem_ready it SHALL force ACCESS -> DONE with load data 0, suppress wb_en, and set bus_err until reset.
REQ-034 When MEM_TIMEOUT_EN is undefined, there SHALL be no counter and no bus_err port, and ACCESS SHALL wait indefinitely.

Verification
REQ-035 ALU op, rd=5, alu_in=0x1234, wb_lines=001 -> next cycle wb_en=1, wb_addr=5, wb_data=0x1234, stall=0.
REQ-036 Load, rd=3, alu_in=0x100, wb_lines=011, mem_ready after 3 cycles with rdata=0xDEADBEEF -> mem_addr=0x100 held; stall=1 for 3 cycles; in DONE, wb_data=0xDEADBEEF and wb_en=1 for one cycle.
REQ-037 Store, alu_in=0x200, store_in=0xCAFE, mem_ready same cycle -> mem_we=1, mem_wdata=0xCAFE, one stall cycle, wb_en=0.
REQ-038 Jump-and-link, ip_in=0x3FFFFFFF, wb_lines=101, rd=1 -> wb_data=0x00000000 (wrap-around).
REQ-039 rd=0 with wb_lines=001 -> wb_en=0; rst_n low mid-ACCESS -> mem_valid=0 immediately and no writeback after release.
REQ-040 With MEM_TIMEOUT_EN defined, mem_ready held at 0 -> ACCESS exits after 255 cycles, bus_err=1, wb_en=0.
